// File: rtl/memory_loader.sv
// Byte-stream boot loader: LE header (start address, word count) then payload words, one WORD store each.
// Define MEMORY_LOADER_VERIFY_READBACK_EN to add a readback VERIFY cycle after every store.

module memory_loader #(
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  byteIn,
  input  logic        byteValid,
  output logic        byteReady,
  output logic [31:0] address,
  output logic [31:0] data,
  output logic [2:0]  writeMode,
  output logic [2:0]  readMode,
  input  logic [31:0] readData,
  output logic        cpuHold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  errorCode
);

  localparam logic [2:0]  MODE_NONE    = 3'd0;
  localparam logic [2:0]  MODE_WORD    = 3'd3;
  localparam logic [2:0]  ERR_NONE     = 3'd0;
  localparam logic [2:0]  ERR_ALIGN    = 3'd1;
  localparam logic [2:0]  ERR_RANGE    = 3'd2;
  localparam logic [2:0]  ERR_TIMEOUT  = 3'd3;
`ifdef MEMORY_LOADER_VERIFY_READBACK_EN
  localparam logic [2:0]  ERR_VERIFY   = 3'd4;
`endif
  localparam logic [34:0] SPAN         = 35'd1 << ADDR_WIDTH;
  localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR_ADDR,
    S_HDR_CNT,
    S_CHECK,
    S_PAYLOAD,
    S_WRITE,
`ifdef MEMORY_LOADER_VERIFY_READBACK_EN
    S_VERIFY,
`endif
    S_DONE,
    S_ERROR
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] start_addr_q, start_addr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] idle_cnt_q, idle_cnt_d;
  logic [31:0] address_q, address_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  err_code_q, err_code_d;

  logic        byte_fire;
  logic        stall;
  logic        last_word;
  logic [31:0] word_in;
  logic [34:0] end_addr;

  assign byteReady = (state_q == S_HDR_ADDR) || (state_q == S_HDR_CNT) || (state_q == S_PAYLOAD);
  assign byte_fire = byteReady && byteValid;
  assign stall     = byteReady && !byteValid;
  // Little-endian assembly: after four shifts the first byte lands in [7:0].
  assign word_in   = {byteIn, shift_q[31:8]};
  assign end_addr  = {3'b000, start_addr_q} + {1'b0, count_q, 2'b00};
  assign last_word = (idx_q + 32'd1) == count_q;

  // NOTE: every next-state variable gets its hold value first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    byte_cnt_d   = byte_cnt_q;
    start_addr_d = start_addr_q;
    count_d      = count_q;
    idx_d        = idx_q;
    idle_cnt_d   = idle_cnt_q;
    address_d    = address_q;
    data_d       = data_q;
    err_code_d   = err_code_q;

    if (byte_fire) begin
      shift_d    = word_in;
      byte_cnt_d = byte_cnt_q + 2'd1;
      idle_cnt_d = '0;
    end else if (stall) begin
      idle_cnt_d = idle_cnt_q + 32'd1;
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_HDR_ADDR;
          err_code_d = ERR_NONE;
          byte_cnt_d = '0;
          idx_d      = '0;
          idle_cnt_d = '0;
        end
      end
      S_HDR_ADDR: begin
        if (byte_fire && byte_cnt_q == 2'd3) begin
          start_addr_d = word_in;
          state_d      = S_HDR_CNT;
        end
      end
      S_HDR_CNT: begin
        if (byte_fire && byte_cnt_q == 2'd3) begin
          count_d = word_in;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (start_addr_q[1:0] != 2'b00) begin
          state_d    = S_ERROR;
          err_code_d = ERR_ALIGN;
        end else if (end_addr > SPAN) begin
          state_d    = S_ERROR;
          err_code_d = ERR_RANGE;
        end else if (count_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (byte_fire && byte_cnt_q == 2'd3) begin
          data_d    = word_in;
          address_d = start_addr_q + {idx_q[29:0], 2'b00};
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
`ifdef MEMORY_LOADER_VERIFY_READBACK_EN
        state_d = S_VERIFY;
`else
        idx_d   = idx_q + 32'd1;
        state_d = last_word ? S_DONE : S_PAYLOAD;
`endif
      end
`ifdef MEMORY_LOADER_VERIFY_READBACK_EN
      S_VERIFY: begin
        if (readData != data_q) begin
          state_d    = S_ERROR;
          err_code_d = ERR_VERIFY;
        end else begin
          idx_d   = idx_q + 32'd1;
          state_d = last_word ? S_DONE : S_PAYLOAD;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Stalls only happen in byte-accepting states, so this never collides with a field completing.
    if (TIMEOUT_EN && stall && idle_cnt_q == TIMEOUT_LAST) begin
      state_d    = S_ERROR;
      err_code_d = ERR_TIMEOUT;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      byte_cnt_q   <= '0;
      start_addr_q <= '0;
      count_q      <= '0;
      idx_q        <= '0;
      idle_cnt_q   <= '0;
      address_q    <= '0;
      data_q       <= '0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      byte_cnt_q   <= byte_cnt_d;
      start_addr_q <= start_addr_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      idle_cnt_q   <= idle_cnt_d;
      address_q    <= address_d;
      data_q       <= data_d;
      err_code_q   <= err_code_d;
    end
  end

  assign writeMode = (state_q == S_WRITE) ? MODE_WORD : MODE_NONE;
`ifdef MEMORY_LOADER_VERIFY_READBACK_EN
  assign readMode  = (state_q == S_VERIFY) ? MODE_WORD : MODE_NONE;
`else
  assign readMode  = MODE_NONE;
  logic unused_read_data;
  assign unused_read_data = ^readData;
`endif

  assign busy      = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
  assign cpuHold   = busy;
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERROR);
  assign errorCode = err_code_q;
  assign address   = address_q;
  assign data      = data_q;

endmodule

// File: tb/tb_memory_loader.sv
// Directed bench for memory_loader: byte-addressed memory model plus a scoreboard of expected stores.
module tb_memory_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  byteIn;
  logic        byteValid;
  logic        byteReady;
  logic [31:0] address;
  logic [31:0] data;
  logic [2:0]  writeMode;
  logic [2:0]  readMode;
  logic [31:0] readData;
  logic        cpuHold;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  errorCode;

  int checks      = 0;
  int errors      = 0;
  int writes_seen = 0;
  logic rd_zero   = 1'b0;

  logic [7:0]  mem [0:65535];
  logic [15:0] ra;
  logic [15:0] wa;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  memory_loader #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start(start), .byteIn(byteIn), .byteValid(byteValid),
    .byteReady(byteReady), .address(address), .data(data), .writeMode(writeMode),
    .readMode(readMode), .readData(readData), .cpuHold(cpuHold), .busy(busy),
    .done(done), .error(error), .errorCode(errorCode)
  );

  always #5 clk = ~clk;

  always_comb begin
    ra       = address[15:0];
    readData = rd_zero ? 32'd0 : {mem[ra + 16'd3], mem[ra + 16'd2], mem[ra + 16'd1], mem[ra]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Memory model and scoreboard: every WORD store is committed and matched against the queue.
  always @(negedge clk) begin
    if (!rst && writeMode === 3'd3) begin
      wr_t e;
      writes_seen++;
      wa = address[15:0];
      mem[wa]          = data[7:0];
      mem[wa + 16'd1]  = data[15:8];
      mem[wa + 16'd2]  = data[23:16];
      mem[wa + 16'd3]  = data[31:24];
      check("store_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("store_addr", address, e.addr);
        check("store_data", data, e.data);
      end
    end
  end

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    byteIn    = b;
    byteValid = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = byteReady;
    end
    if (!got) begin
      check("byte_ready_timeout", {31'd0, byteReady}, 32'd1);
      byteValid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      byteValid = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_header(input logic [31:0] a, input logic [31:0] c);
    send_word(a);
    send_word(c);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_term(input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      hit = done || error;
    end
    check(tag, {31'd0, hit}, 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    byteIn    = 8'h00;
    byteValid = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_ctrl", {21'd0, byteReady, cpuHold, busy, done, error, errorCode, writeMode, readMode},
          32'd0);
    check("rst_addr", address, 32'd0);
    check("rst_data", data, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Two-word load at 0x100
    writes_seen = 0;
    push_exp(32'h0000_0100, 32'hDEAD_BEEF);
    push_exp(32'h0000_0104, 32'h0123_4567);
    pulse_start();
    check("t1_hold_rise", {30'd0, cpuHold, busy}, 32'd3);
    send_header(32'h0000_0100, 32'd2);
    send_word(32'hDEAD_BEEF);
    send_word(32'h0123_4567);
    wait_term("t1_term");
    check("t1_done", {30'd0, done, error}, 32'd2);
    check("t1_hold_fall", {31'd0, cpuHold}, 32'd0);
    check("t1_writes", writes_seen, 32'd2);
    check("t1_queue_empty", exp_q.size(), 32'd0);
    check("t1_mem_100", {24'd0, mem[16'h0100]}, 32'hEF);
    check("t1_mem_101", {24'd0, mem[16'h0101]}, 32'hBE);
    check("t1_mem_102", {24'd0, mem[16'h0102]}, 32'hAD);
    check("t1_mem_103", {24'd0, mem[16'h0103]}, 32'hDE);

    // Misaligned start address
    writes_seen = 0;
    pulse_start();
    send_header(32'h0000_0102, 32'd1);
    wait_term("t2_term");
    check("t2_error", {30'd0, done, error}, 32'd1);
    check("t2_code", {29'd0, errorCode}, 32'd1);
    check("t2_ready", {31'd0, byteReady}, 32'd0);
    check("t2_hold", {31'd0, cpuHold}, 32'd0);
    check("t2_writes", writes_seen, 32'd0);

    // Range overflow by one word, then an exact fit at the top of memory
    writes_seen = 0;
    pulse_start();
    send_header(32'h0000_FFFC, 32'd2);
    wait_term("t3a_term");
    check("t3a_code", {29'd0, errorCode}, 32'd2);
    check("t3a_writes", writes_seen, 32'd0);
    push_exp(32'h0000_FFFC, 32'hCAFE_F00D);
    pulse_start();
    check("t3b_code_clear", {29'd0, errorCode}, 32'd0);
    send_header(32'h0000_FFFC, 32'd1);
    send_word(32'hCAFE_F00D);
    wait_term("t3b_term");
    check("t3b_done", {30'd0, done, error}, 32'd2);
    check("t3b_writes", writes_seen, 32'd1);
    check("t3b_mem_top", {24'd0, mem[16'hFFFF]}, 32'hCA);

    // Zero word count
    writes_seen = 0;
    pulse_start();
    send_header(32'h0000_0200, 32'd0);
    wait_term("t4_term");
    check("t4_done", {30'd0, done, error}, 32'd2);
    check("t4_hold", {31'd0, cpuHold}, 32'd0);
    check("t4_writes", writes_seen, 32'd0);

    // Timeout after two payload bytes, then a clean restart
    writes_seen = 0;
    pulse_start();
    send_header(32'h0000_0300, 32'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
    end
    check("t5_no_error_15", {31'd0, error}, 32'd0);
    @(posedge clk);
    #1;
    check("t5_error_16", {31'd0, error}, 32'd1);
    check("t5_code", {29'd0, errorCode}, 32'd3);
    check("t5_writes", writes_seen, 32'd0);
    push_exp(32'h0000_0300, 32'h89AB_CDEF);
    pulse_start();
    check("t5_restart_clear", {28'd0, error, errorCode}, 32'd0);
    send_header(32'h0000_0300, 32'd1);
    send_word(32'h89AB_CDEF);
    wait_term("t5_restart_term");
    check("t5_restart_done", {30'd0, done, error}, 32'd2);
    check("t5_queue_empty", exp_q.size(), 32'd0);

    // Asynchronous reset mid-payload
    pulse_start();
    send_header(32'h0000_0400, 32'd2);
    send_byte(8'h55);
    rst = 1'b1;
    #1;
    check("t6_rst_ctrl", {21'd0, byteReady, cpuHold, busy, done, error, errorCode, writeMode, readMode},
          32'd0);
    check("t6_rst_addr", address, 32'd0);
    check("t6_rst_data", data, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

`ifdef MEMORY_LOADER_VERIFY_READBACK_EN
    // Readback mismatch with memory output forced to zero
    writes_seen = 0;
    rd_zero     = 1'b1;
    push_exp(32'h0000_0500, 32'h1357_2468);
    pulse_start();
    send_header(32'h0000_0500, 32'd2);
    send_word(32'h1357_2468);
    wait_term("t7_term");
    check("t7_code", {29'd0, errorCode}, 32'd4);
    check("t7_error", {30'd0, done, error}, 32'd1);
    check("t7_addr", address, 32'h0000_0500);
    check("t7_writes", writes_seen, 32'd1);
    rd_zero = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
